vector_list_writer: RTL and testbench

//  Loader for the vector machine: accepts a stream of element values and writes them into
//  the 512x24 vector memory as the linked node list that the control unit traverses.

---
 rtl/vector_list_writer.sv | 157 +++++++++++++++
 tb/tb_vector_list_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_list_writer.sv
// Builds the doubly linked node list in the 512x24 vector memory from an element stream, then pulses Go.
// Latency: accept -> WE one cycle later; last accept -> Go two cycles later. Optional VLW_CHECKSUM_EN adds Exp_Sum.
// Backpressure: In_Ready high only in S_LOAD; one node per cycle when In_Valid is held high.
module vector_list_writer #(
    parameter int WORD_W = 24,
    parameter int ADDR_W = 9,
    parameter int VAL_W  = WORD_W - ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Load,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [VAL_W-1:0]  In_Data,
    input  logic              In_Last,
    output logic              WE,
    output logic [ADDR_W-1:0] WAdress1,
    output logic [ADDR_W-1:0] WAdress2,
    output logic [WORD_W-1:0] WData1,
    output logic [WORD_W-1:0] WData2,
    output logic              Go,
    output logic              Done,
`ifdef VLW_CHECKSUM_EN
    output logic              Overflow,
    output logic [2*VAL_W+ADDR_W-2:0] Exp_Sum
`else
    output logic              Overflow
`endif
);

    localparam logic [ADDR_W-1:0] ZERO_PTR = '0;
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_PTR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] LAST_PTR = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_node_ptr;
    logic [ADDR_W-1:0] r_prev_ptr;
    logic              w_accept;
    logic              w_cap;
    logic              w_last;
    logic              w_start;
    logic              w_go_set;

    assign w_accept = In_Valid && (r_state == S_LOAD);
    // The final node slot always terminates the list, whether or not the stream did.
    assign w_cap    = (r_node_ptr == LAST_PTR);
    assign w_last   = In_Last || w_cap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_go_set = 1'b0;
        In_Ready = 1'b0;
        Done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Load) begin
                    w_next  = S_LOAD;
                    w_start = 1'b1;
                end
            end
            S_LOAD: begin
                In_Ready = 1'b1;
                if (w_accept && w_last) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next   = S_DONE;
                w_go_set = 1'b1;
            end
            S_DONE: begin
                Done = 1'b1;
                if (Load) begin
                    w_next  = S_LOAD;
                    w_start = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WE         <= 1'b0;
            Go         <= 1'b0;
            Overflow   <= 1'b0;
            WAdress1   <= '0;
            WAdress2   <= '0;
            WData1     <= '0;
            WData2     <= '0;
            r_node_ptr <= '0;
            r_prev_ptr <= '0;
        end else begin
            WE <= w_accept;
            Go <= w_go_set;
            if (w_start) begin
                r_node_ptr <= '0;
                r_prev_ptr <= '0;
                Overflow   <= 1'b0;
            end else if (w_accept) begin
                WAdress1   <= r_node_ptr;
                WAdress2   <= r_node_ptr + ONE_PTR;
                WData1     <= {In_Data, (w_last ? ZERO_PTR : r_node_ptr + TWO_PTR)};
                WData2     <= {{VAL_W{1'b0}}, r_prev_ptr};
                r_prev_ptr <= r_node_ptr;
                // Pointer stays on the final node so it can never wrap back to the head.
                if (!w_last) begin
                    r_node_ptr <= r_node_ptr + TWO_PTR;
                end
                if (w_cap && !In_Last) begin
                    Overflow <= 1'b1;
                end
            end
        end
    end

`ifdef VLW_CHECKSUM_EN
    localparam int SUM_W = 2*VAL_W + ADDR_W - 1;

    logic [SUM_W-1:0]   r_sum;
    logic [2*VAL_W-1:0] w_square;

    assign w_square = In_Data * In_Data;
    assign Exp_Sum  = r_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_start) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + SUM_W'(w_square);
        end
    end
`endif

endmodule

// File: tb/tb_vector_list_writer.sv
// Scoreboard bench for vector_list_writer: expected node writes are queued as elements are accepted.
module tb_vector_list_writer;

    typedef struct packed {
        logic [8:0]  a;
        logic [23:0] d1;
        logic [23:0] d2;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Load;
    logic        In_Valid;
    logic        In_Ready;
    logic [14:0] In_Data;
    logic        In_Last;
    logic        WE;
    logic [8:0]  WAdress1;
    logic [8:0]  WAdress2;
    logic [23:0] WData1;
    logic [23:0] WData2;
    logic        Go;
    logic        Done;
    logic        Overflow;
`ifdef VLW_CHECKSUM_EN
    logic [37:0] Exp_Sum;
`endif

    wr_t         q[$];
    wr_t         mon_e;
    logic [8:0]  mon_a2;
    int          checks = 0;
    int          failures = 0;
    int          go_cnt = 0;
    int          wr_cnt = 0;
    logic [8:0]  m_node;
    logic [8:0]  m_prev;
    logic [37:0] m_sum;

    always #5 clk = ~clk;

    vector_list_writer dut (
        .clk      (clk),
        .reset    (rst_n),
        .Load     (Load),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_Data  (In_Data),
        .In_Last  (In_Last),
        .WE       (WE),
        .WAdress1 (WAdress1),
        .WAdress2 (WAdress2),
        .WData1   (WData1),
        .WData2   (WData2),
        .Go       (Go),
        .Done     (Done),
`ifdef VLW_CHECKSUM_EN
        .Overflow (Overflow),
        .Exp_Sum  (Exp_Sum)
`else
        .Overflow (Overflow)
`endif
    );

    always @(negedge clk) begin
        if (rst_n && WE) begin
            wr_cnt++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data1=%h data2=%h", WAdress1, WData1, WData2);
            end else begin
                mon_e  = q.pop_front();
                mon_a2 = mon_e.a + 9'd1;
                if (WAdress1 !== mon_e.a || WAdress2 !== mon_a2 || WData1 !== mon_e.d1 || WData2 !== mon_e.d2) begin
                    failures++;
                    $display("FAIL node_write got a1=%0d a2=%0d d1=%h d2=%h want a1=%0d a2=%0d d1=%h d2=%h",
                             WAdress1, WAdress2, WData1, WData2, mon_e.a, mon_a2, mon_e.d1, mon_e.d2);
                end
            end
        end
        if (rst_n && Go) go_cnt++;
    end

    task automatic idle(input int n);
        In_Valid = 1'b0;
        Load     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load();
        Load = 1'b1;
        @(posedge clk);
        #1;
        Load   = 1'b0;
        m_node = 9'd0;
        m_prev = 9'd0;
        m_sum  = 38'd0;
    endtask

    // Presents one element and waits (bounded) for acceptance; returns one tick after the accepting edge.
    task automatic send(input logic [14:0] v, input logic lst, output logic eff_last, output logic acc);
        wr_t e;
        In_Valid = 1'b1;
        In_Data  = v;
        In_Last  = lst;
        acc      = 1'b0;
        eff_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (In_Ready) begin
                acc      = 1'b1;
                eff_last = lst || (m_node == 9'd510);
                e.a      = m_node;
                e.d1     = {v, (eff_last ? 9'd0 : m_node + 9'd2)};
                e.d2     = {15'd0, m_prev};
                q.push_back(e);
                m_sum  = m_sum + 38'(v) * 38'(v);
                m_prev = m_node;
                if (!eff_last) m_node = m_node + 9'd2;
                @(posedge clk);
                #1;
                break;
            end
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout value=%0d accepted=0 required=1", v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Load = 1'b0; In_Valid = 1'b0; In_Data = '0; In_Last = 1'b0;
        #12;
        checks++; if (WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", WE); end
        checks++; if (In_Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", In_Ready); end
        checks++; if (Go !== 1'b0) begin failures++; $display("FAIL reset_go got=%b want=0", Go); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", Done); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", Overflow); end
        checks++;
        if ({WAdress1, WAdress2, WData1, WData2} !== 66'd0) begin
            failures++;
            $display("FAIL reset_bus got a1=%0d a2=%0d d1=%h d2=%h want all 0", WAdress1, WAdress2, WData1, WData2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        logic el, acc;
        int   g0;
        g0 = go_cnt;
        do_load();
        send(15'd3, 1'b0, el, acc);
        Load = 1'b1;
        send(15'd4, 1'b0, el, acc);
        Load = 1'b0;
        send(15'd5, 1'b1, el, acc);
        In_Valid = 1'b0;
        @(negedge clk);
        checks++; if (Go !== 1'b0 || WE !== 1'b1) begin failures++; $display("FAIL basic_commit got go=%b we=%b want go=0 we=1", Go, WE); end
        @(negedge clk);
        checks++; if (Go !== 1'b1 || Done !== 1'b1) begin failures++; $display("FAIL basic_go got go=%b done=%b want 1 1", Go, Done); end
        @(negedge clk);
        checks++; if (Go !== 1'b0) begin failures++; $display("FAIL basic_go_width got=%b want=0", Go); end
        In_Valid = 1'b1; In_Data = 15'd9; In_Last = 1'b1;
        idle(0);
        repeat (3) @(negedge clk);
        In_Valid = 1'b0;
        checks++; if (In_Ready !== 1'b0 || Done !== 1'b1) begin failures++; $display("FAIL basic_done got ready=%b done=%b want 0 1", In_Ready, Done); end
        checks++; if (go_cnt - g0 != 1) begin failures++; $display("FAIL basic_go_count got=%0d want=1", go_cnt - g0); end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL basic_pending got=%0d want=0", q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic el, acc;
        int   g0;
        g0 = go_cnt;
        do_load();
        send(15'd7, 1'b1, el, acc);
        In_Valid = 1'b0;
        @(negedge clk);
        checks++; if (WData1 !== {15'd7, 9'd0} || WData2 !== 24'd0) begin failures++; $display("FAIL single_data got d1=%h d2=%h want %h 0", WData1, WData2, {15'd7, 9'd0}); end
        @(negedge clk);
        checks++; if (Go !== 1'b1) begin failures++; $display("FAIL single_go got=%b want=1", Go); end
        idle(3);
        checks++; if (go_cnt - g0 != 1 || q.size() != 0) begin failures++; $display("FAIL single_end got go=%0d pend=%0d want 1 0", go_cnt - g0, q.size()); end
    endtask

    task automatic test_toggle();
        logic el, acc;
        int   g0, w0;
        g0 = go_cnt;
        w0 = wr_cnt;
        do_load();
        for (int i = 0; i < 5; i++) begin
            send(15'(100 + i), (i == 4), el, acc);
            In_Valid = 1'b0;
            @(posedge clk); #1;
        end
        idle(4);
        checks++; if (wr_cnt - w0 != 5) begin failures++; $display("FAIL toggle_writes got=%0d want=5", wr_cnt - w0); end
        checks++; if (go_cnt - g0 != 1 || q.size() != 0) begin failures++; $display("FAIL toggle_end got go=%0d pend=%0d want 1 0", go_cnt - g0, q.size()); end
    endtask

    task automatic test_overflow();
        logic el, acc;
        int   n, w0, g0, rdy_seen;
        n = 0; rdy_seen = 0;
        w0 = wr_cnt;
        g0 = go_cnt;
        do_load();
        for (int i = 0; i < 300; i++) begin
            send(15'(i + 1), 1'b0, el, acc);
            if (acc) n++;
            if (el || !acc) break;
        end
        In_Valid = 1'b1; In_Last = 1'b0;
        @(negedge clk);
        checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", Overflow); end
        repeat (6) begin
            @(negedge clk);
            if (In_Ready) rdy_seen++;
        end
        In_Valid = 1'b0;
        checks++; if (n != 256) begin failures++; $display("FAIL ovf_accepts got=%0d want=256", n); end
        checks++; if (rdy_seen != 0) begin failures++; $display("FAIL ovf_ready got=%0d want=0", rdy_seen); end
        checks++; if (wr_cnt - w0 != 256 || go_cnt - g0 != 1) begin failures++; $display("FAIL ovf_counts got wr=%0d go=%0d want 256 1", wr_cnt - w0, go_cnt - g0); end
        @(posedge clk); #1;
        do_load();
        @(negedge clk);
        checks++; if (Overflow !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL ovf_clear got ovf=%b done=%b want 0 0", Overflow, Done); end
        @(posedge clk); #1;
        send(15'd9, 1'b1, el, acc);
        idle(4);
    endtask

`ifdef VLW_CHECKSUM_EN
    task automatic test_checksum();
        logic el, acc;
        do_load();
        send(15'd1, 1'b0, el, acc);
        send(15'd2, 1'b0, el, acc);
        send(15'd3, 1'b1, el, acc);
        idle(3);
        checks++; if (Done !== 1'b1 || Exp_Sum !== 38'd14) begin failures++; $display("FAIL checksum got done=%b sum=%0d want 1 14", Done, Exp_Sum); end
        checks++; if (Exp_Sum !== m_sum) begin failures++; $display("FAIL checksum_model got=%0d want=%0d", Exp_Sum, m_sum); end
        do_load();
        @(negedge clk);
        checks++; if (Exp_Sum !== 38'd0) begin failures++; $display("FAIL checksum_clear got=%0d want=0", Exp_Sum); end
        @(posedge clk); #1;
        send(15'd5, 1'b1, el, acc);
        idle(4);
    endtask
`endif

    task automatic test_reset_mid();
        logic el, acc;
        int   g0;
        g0 = go_cnt;
        do_load();
        send(15'd11, 1'b0, el, acc);
        send(15'd12, 1'b0, el, acc);
        In_Valid = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        checks++; if (WE !== 1'b0) begin failures++; $display("FAIL midreset_we got=%b want=0", WE); end
        checks++; if (In_Ready !== 1'b0) begin failures++; $display("FAIL midreset_ready got=%b want=0", In_Ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        In_Valid = 1'b1; In_Data = 15'd13; In_Last = 1'b1;
        repeat (6) @(negedge clk);
        In_Valid = 1'b0;
        checks++; if (In_Ready !== 1'b0 || Done !== 1'b0 || WE !== 1'b0) begin failures++; $display("FAIL midreset_idle got ready=%b done=%b we=%b want 0 0 0", In_Ready, Done, WE); end
        checks++; if (go_cnt != g0) begin failures++; $display("FAIL midreset_go got=%0d want=0", go_cnt - g0); end
        @(posedge clk); #1;
    endtask

    initial begin
        m_node = 9'd0; m_prev = 9'd0; m_sum = 38'd0;
        test_reset();
        test_basic();
        test_single();
        test_toggle();
        test_overflow();
`ifdef VLW_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

endmodule
